// File: rtl/mux_select_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-requester mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Convert a requester index into its one-hot grant pattern.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux_select_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               address0;
  logic               address1;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  address0,
    input  address1
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output address0,
    output address1
  );

endinterface

// File: rtl/mux_select_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible requester after 'last',
// wrapping 3 -> 0. Masked lines are skipped.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   last,
  output logic               hit,
  output logic [IDX_W-1:0]   win_idx
);

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] cand_ok;

  assign eligible = req & ~mask;

  // Candidate gi is the requester gi+1 places after the last winner; the
  // final candidate is the last winner itself (2-bit wrap).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi]    = last + IDX_W'(gi + 1);
      assign cand_ok[gi] = eligible[cand[gi]];
    end
  endgenerate

  // Lowest-numbered eligible candidate wins (closest to the last winner).
  always_comb begin
    hit     = |cand_ok;
    win_idx = cand[NUM_REQ-1];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_ok[k]) win_idx = cand[k];
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the selects of a shared 4:1 single-bit mux.
// Optional feature macro: MUX_ARB_TIMEOUT_EN (bounded hold of MAX_HOLD cycles
// while others wait). Without it an owner keeps the mux until it drops req.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_select_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_BUSY = BUSY;

  logic [0:0]         state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic               grant_valid_reg;
  logic [IDX_W-1:0]   addr_reg;
  logic [IDX_W-1:0]   last_reg;

  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               take;
  logic               go_idle;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_reg;
  logic             hold_at_limit;
  assign hold_at_limit = (hold_reg == HOLD_LAST);
`endif

  // The current owner is excluded from a handover pick so it cannot re-win.
  assign pick_mask = (state_reg == S_BUSY) ? grant_reg : '0;
  assign owner_req = |(bus.req & grant_reg);

  rr_pick4 u_pick (
    .req     (bus.req),
    .mask    (pick_mask),
    .last    (last_reg),
    .hit     (pick_hit),
    .win_idx (pick_idx)
  );

  // Decide whether the next edge grants a new owner or returns to idle.
  always_comb begin
    take    = 1'b0;
    go_idle = 1'b0;
    if (state_reg == S_IDLE) begin
      take = pick_hit;
    end else if (!owner_req) begin
      take    = pick_hit;
      go_idle = !pick_hit;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    else if (hold_at_limit) begin
      take = pick_hit;
    end
`endif
  end

  // FSM, last-winner pointer and registered outputs; address is left alone on idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      addr_reg        <= '0;
      last_reg        <= IDX_W'(NUM_REQ - 1);
    end else if (take) begin
      state_reg       <= S_BUSY;
      grant_reg       <= idx_to_onehot(pick_idx);
      grant_valid_reg <= 1'b1;
      addr_reg        <= pick_idx;
      last_reg        <= pick_idx;
    end else if (go_idle) begin
      state_reg       <= S_IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter: cleared on each new grant, counts BUSY cycles, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (take) begin
      hold_reg <= '0;
    end else if (state_reg == S_BUSY && !hold_at_limit) begin
      hold_reg <= hold_reg + 1'b1;
    end
  end
`endif

  assign bus.grant       = grant_reg;
  assign bus.grant_valid = grant_valid_reg;
  assign bus.address0    = addr_reg[0];
  assign bus.address1    = addr_reg[1];

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: a behavioural model predicts the
// outputs for each driven request pattern; predictions are queued and compared
// one cycle later. Timeout cases follow MUX_ARB_TIMEOUT_EN if defined.
module tb_mux_select_arbiter;

  localparam int TB_HOLD = 4;

  logic clk;
  logic rst_n;

  mux_select_arbiter_if bus ();

  mux_select_arbiter #(.MAX_HOLD(TB_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       gv;
    logic [1:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_busy;
  logic [1:0] m_owner;
  logic [1:0] m_last;
  logic [1:0] m_addr;
  int         m_hold;

  task automatic m_reset();
    m_busy = 1'b0; m_owner = 2'd0; m_last = 2'd3; m_addr = 2'd0; m_hold = 0;
  endtask

  // Returns {hit, idx}: scan last+1, last+2, ... wrapping over four lines.
  function automatic logic [2:0] m_pick(logic [3:0] r, logic [3:0] msk, logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (int'(last) + k) % 4;
      if (r[j] && !msk[j]) return {1'b1, 2'(j)};
    end
    return 3'b000;
  endfunction

  task automatic m_take(input logic [1:0] w);
    m_busy = 1'b1; m_owner = w; m_last = w; m_addr = w; m_hold = 0;
  endtask

  task automatic m_step(input logic [3:0] r);
    logic [2:0] p;
    logic [3:0] own;
    own = 4'b0001 << m_owner;
    if (!m_busy) begin
      p = m_pick(r, 4'b0000, m_last);
      if (p[2]) m_take(p[1:0]);
    end else if (!r[m_owner]) begin
      p = m_pick(r, own, m_last);
      if (p[2]) m_take(p[1:0]);
      else m_busy = 1'b0;
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_hold == TB_HOLD - 1) begin
        p = m_pick(r, own, m_last);
        if (p[2]) m_take(p[1:0]);
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  // Apply one request pattern for one cycle and score the result.
  task automatic drive(input logic [3:0] r);
    exp_t e;
    bus.req = r;
    m_step(r);
    e.grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.gv    = m_busy;
    e.addr  = m_addr;
    q.push_back(e);
    @(negedge clk);
    if (q.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check_val("sb_grant", bus.grant, e.grant);
      check_val("sb_gv", bus.grant_valid, e.gv);
      check_val("sb_addr", {bus.address1, bus.address0}, e.addr);
      $display("req=%b grant=%b gv=%b addr=%0d", r, bus.grant, bus.grant_valid,
               {bus.address1, bus.address0});
    end
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_grant", bus.grant, 4'b0000);
    check_val("rst_gv", bus.grant_valid, 0);
    check_val("rst_addr", {bus.address1, bus.address0}, 2'd0);
    rst_n = 1'b1;
    m_reset();
    q.delete();
  endtask

  // Invariants every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("inv_onehot0", $onehot0(bus.grant), 1);
      check_val("inv_gv", bus.grant_valid, |bus.grant);
      if (bus.grant_valid) begin
        logic [1:0] gi_idx;
        gi_idx = 2'd0;
        for (int i = 0; i < 4; i++) if (bus.grant[i]) gi_idx = 2'(i);
        check_val("inv_addr", {bus.address1, bus.address0}, gi_idx);
      end
    end
  end

  logic [3:0] fair_req [10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111};
  logic [3:0] fair_gnt [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    m_reset();
    @(negedge clk);

    // Basic grant and back-to-back handover.
    do_reset();
    drive(4'b1111);
    check_val("first_grant", bus.grant, 4'b0001);
    check_val("first_addr", {bus.address1, bus.address0}, 2'd0);
    drive(4'b1110);
    check_val("handover_grant", bus.grant, 4'b0010);
    check_val("handover_addr", {bus.address1, bus.address0}, 2'd1);

    // Fairness: each owner releases after two grant cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(fair_req[k]);
      check_val("fair_grant", bus.grant, fair_gnt[k]);
    end

    // Single requester, then address retention in idle.
    drive(4'b0000);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100);
      check_val("single_grant", bus.grant, 4'b0100);
      check_val("single_addr", {bus.address1, bus.address0}, 2'd2);
    end
    drive(4'b0000);
    check_val("idle_grant", bus.grant, 4'b0000);
    check_val("idle_gv", bus.grant_valid, 0);
    check_val("idle_addr", {bus.address1, bus.address0}, 2'd2);

    // Asynchronous reset between edges while 1000 is granted.
    drive(4'b1000);
    drive(4'b1000);
    check_val("pre_rst_grant", bus.grant, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_grant", bus.grant, 4'b0000);
    check_val("async_gv", bus.grant_valid, 0);
    check_val("async_addr", {bus.address1, bus.address0}, 2'd0);
    q.delete();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1000);
    check_val("post_rst_grant", bus.grant, 4'b1000);

    // Two requesters held constant: bounded hold only with the timeout feature.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(4'b0011);
`ifdef MUX_ARB_TIMEOUT_EN
      check_val("hold_grant", bus.grant, ((k / TB_HOLD) % 2 == 1) ? 4'b0010 : 4'b0001);
`else
      check_val("hold_grant", bus.grant, 4'b0001);
`endif
    end

    // Random traffic, scoreboard only.
    for (int k = 0; k < 80; k++) begin
      drive(4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
